// File: rtl/lzc_wide_seq.sv
// Multi-cycle leading-zero counter: scans a wide operand one chunk per cycle,
// MSB chunk first, through a single shared chunk-wide LZC.
module lzc_wide_seq #(
    parameter int DATA_WIDTH  = 256,
    parameter int CHUNK_WIDTH = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH-1:0]             in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [$clog2(DATA_WIDTH+1)-1:0]   out_count,
    output logic                              out_is_zero,
    output logic                              busy
);
    localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int CNT_W      = $clog2(DATA_WIDTH + 1);
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int LZ_W       = $clog2(CHUNK_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                  state, next_state;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [IDX_W-1:0]        idx;
    logic [CHUNK_WIDTH-1:0]  top_chunk;
    logic [LZ_W-1:0]         chunk_lz;
    logic                    chunk_zero;
    logic                    last_chunk;

    function automatic logic [LZ_W-1:0] lzc_chunk(input logic [CHUNK_WIDTH-1:0] x);
        logic            found;
        logic [LZ_W-1:0] n;
        found = 1'b0;
        n     = '0;
        for (int i = CHUNK_WIDTH - 1; i >= 0; i--) begin
            if (!found) begin
                if (x[i]) found = 1'b1;
                else      n = n + LZ_W'(1);
            end
        end
        return n;
    endfunction

    assign top_chunk  = shift_reg[DATA_WIDTH-1 -: CHUNK_WIDTH];
    assign chunk_lz   = lzc_chunk(top_chunk);
    assign chunk_zero = ~|top_chunk;
    assign last_chunk = (idx == IDX_W'(NUM_CHUNKS - 1));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = SCAN;
            SCAN:    if (!chunk_zero || last_chunk) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: result registers stay untouched in DONE so they hold until handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg   <= '0;
            idx         <= '0;
            out_count   <= '0;
            out_is_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg <= in_data;
                        idx       <= '0;
                    end
                end
                SCAN: begin
                    if (!chunk_zero) begin
                        out_count   <= CNT_W'(idx) * CNT_W'(CHUNK_WIDTH) + CNT_W'(chunk_lz);
                        out_is_zero <= 1'b0;
                    end else if (last_chunk) begin
                        out_count   <= CNT_W'(DATA_WIDTH);
                        out_is_zero <= 1'b1;
                    end else begin
                        shift_reg <= shift_reg << CHUNK_WIDTH;
                        idx       <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
